// File: rtl/player_lives_if.sv
// Pixel-flag inputs and life/status outputs between the raster pipeline and player_lives_ctrl.
// The pickup_on flag exists only when PLAYER_LIVES_EXTRA_EN is defined.
interface player_lives_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       bm_hb_on;
    logic       exp_on;
    logic       enemy_on;
    logic       restart;
`ifdef PLAYER_LIVES_EXTRA_EN
    logic       pickup_on;
`endif
    logic [2:0] lives;
    logic       gameover;
    logic       hit_pulse;
    logic       invuln;
    logic       blink;

`ifdef PLAYER_LIVES_EXTRA_EN
    modport master (output x, y, bm_hb_on, exp_on, enemy_on, restart, pickup_on,
                    input  lives, gameover, hit_pulse, invuln, blink);
    modport slave  (input  x, y, bm_hb_on, exp_on, enemy_on, restart, pickup_on,
                    output lives, gameover, hit_pulse, invuln, blink);
`else
    modport master (output x, y, bm_hb_on, exp_on, enemy_on, restart,
                    input  lives, gameover, hit_pulse, invuln, blink);
    modport slave  (input  x, y, bm_hb_on, exp_on, enemy_on, restart,
                    output lives, gameover, hit_pulse, invuln, blink);
`endif
endinterface

// File: rtl/player_lives_ctrl.sv
// Per-frame player hit detection, life counter, invulnerability window and gameover.
// Optional extra-life pickups are enabled with the PLAYER_LIVES_EXTRA_EN macro.
module player_lives_ctrl #(
    parameter int MAX_LIVES     = 5,
    parameter int INVULN_FRAMES = 120,
    parameter int FRAME_Y       = 480,
    parameter int BLINK_BIT     = 3
) (
    input logic           clk,
    input logic           reset,
    player_lives_if.slave bus
);
    localparam int CW = $clog2(INVULN_FRAMES + 1);

    typedef enum logic [1:0] {ALIVE, HIT, INVULN, DEAD} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      lives_reg, lives_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            col_reg, col_next;
    logic            cmp_reg;
    logic            tick_reg;
    logic            hit_pulse_reg;
    logic            blink_reg;
    logic            cmp;
    logic            col_set;
`ifdef PLAYER_LIVES_EXTRA_EN
    logic            pick_reg, pick_next;
    logic            pick_set;
    logic            pickup_ok;
`endif

    // Edge of the boundary compare, so a stalled raster position still ticks only once.
    assign cmp     = (bus.x == 10'd0) && (bus.y == 10'(FRAME_Y));
    assign col_set = bus.bm_hb_on && (bus.exp_on || bus.enemy_on);
`ifdef PLAYER_LIVES_EXTRA_EN
    assign pick_set = bus.bm_hb_on && bus.pickup_on;
`endif

    always_comb begin
        state_next = state_reg;
        lives_next = lives_reg;
        cnt_next   = cnt_reg;
        // A set on the tick cycle wins, carrying the hit into the next frame.
        col_next   = col_set | (col_reg & ~tick_reg);
`ifdef PLAYER_LIVES_EXTRA_EN
        pick_next  = pick_set | (pick_reg & ~tick_reg);
        pickup_ok  = 1'b0;
`endif
        case (state_reg)
            ALIVE: begin
                if (tick_reg && col_reg) begin
                    state_next = HIT;
                end
`ifdef PLAYER_LIVES_EXTRA_EN
                else begin
                    pickup_ok = tick_reg & pick_reg;
                end
`endif
            end
            HIT: begin
                lives_next = lives_reg - 3'd1;
                if (lives_reg == 3'd1) begin
                    state_next = DEAD;
                end else begin
                    state_next = INVULN;
                    cnt_next   = '0;
                end
            end
            INVULN: begin
                if (tick_reg) begin
                    if (cnt_reg == CW'(INVULN_FRAMES - 1)) begin
                        state_next = ALIVE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`ifdef PLAYER_LIVES_EXTRA_EN
                pickup_ok = tick_reg & pick_reg;
`endif
            end
            DEAD: begin
                if (bus.restart) begin
                    state_next = ALIVE;
                    lives_next = 3'(MAX_LIVES);
                    col_next   = col_set;
`ifdef PLAYER_LIVES_EXTRA_EN
                    pick_next  = pick_set;
`endif
                end
            end
            default: state_next = ALIVE;
        endcase
`ifdef PLAYER_LIVES_EXTRA_EN
        if (pickup_ok && (lives_reg < 3'(MAX_LIVES))) begin
            lives_next = lives_reg + 3'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ALIVE;
            lives_reg     <= 3'(MAX_LIVES);
            cnt_reg       <= '0;
            col_reg       <= 1'b0;
            cmp_reg       <= 1'b0;
            tick_reg      <= 1'b0;
            hit_pulse_reg <= 1'b0;
            blink_reg     <= 1'b1;
`ifdef PLAYER_LIVES_EXTRA_EN
            pick_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            lives_reg     <= lives_next;
            cnt_reg       <= cnt_next;
            col_reg       <= col_next;
            cmp_reg       <= cmp;
            tick_reg      <= cmp & ~cmp_reg;
            hit_pulse_reg <= (state_reg == HIT);
            blink_reg     <= (state_reg != INVULN) | cnt_reg[BLINK_BIT];
`ifdef PLAYER_LIVES_EXTRA_EN
            pick_reg      <= pick_next;
`endif
        end
    end

    assign bus.lives     = lives_reg;
    assign bus.gameover  = (state_reg == DEAD);
    assign bus.hit_pulse = hit_pulse_reg;
    assign bus.invuln    = (state_reg == INVULN);
    assign bus.blink     = blink_reg;
endmodule

// File: tb/tb_player_lives_ctrl.sv
// Directed bench for player_lives_ctrl: short synthetic frames drive the x/y boundary
// and overlap flags; expected values are hand-computed per step.
module tb_player_lives_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   hit_cnt;
    int   exp_hits;

    player_lives_if bus ();

    player_lives_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.hit_pulse === 1'b1) hit_cnt <= hit_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic set_pix(input logic bm, input logic ex, input logic en, input logic pk);
        bus.bm_hb_on = bm;
        bus.exp_on   = ex;
        bus.enemy_on = en;
`ifdef PLAYER_LIVES_EXTRA_EN
        bus.pickup_on = pk;
`else
        if (pk) $display("pickup ignored in this build");
`endif
    endtask

    // kind: 0 none, 1 explosion overlap, 2 enemy overlap, 3 explosion/enemy without hitbox
    task automatic frame(input int kind, input logic pick, input logic on_tick);
        @(negedge clk);
        bus.x = 10'd10; bus.y = 10'd100;
        set_pix((kind == 1) || (kind == 2) || pick, (kind == 1) || (kind == 3),
                (kind == 2) || (kind == 3), pick);
        @(negedge clk);
        set_pix(1'b0, 1'b0, 1'b0, 1'b0);
        bus.x = 10'd11;
        @(negedge clk);
        bus.x = 10'd0; bus.y = 10'd480;
        @(negedge clk);
        if (on_tick) set_pix(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        set_pix(1'b0, 1'b0, 1'b0, 1'b0);
        bus.x = 10'd1;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n, input int kind);
        for (int i = 0; i < n; i++) frame(kind, 1'b0, 1'b0);
    endtask

    task automatic pulse_restart;
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; hit_cnt = 0; exp_hits = 0;
        bus.x = 10'd1; bus.y = 10'd0; bus.restart = 1'b0;
        set_pix(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_lives", bus.lives, 5);
        check("rst_gameover", bus.gameover, 0);
        check("rst_invuln", bus.invuln, 0);
        check("rst_blink", bus.blink, 1);
        check("rst_hit_pulse", bus.hit_pulse, 0);
        reset = 1'b0;

        frames(3, 0);
        frame(3, 1'b0, 1'b0);
        check("idle_lives", bus.lives, 5);
        check("idle_hits", hit_cnt, 0);
        check("idle_invuln", bus.invuln, 0);
        check("idle_blink", bus.blink, 1);

        frame(1, 1'b0, 1'b0); exp_hits++;
        check("hit1_lives", bus.lives, 4);
        check("hit1_pulse_cycles", hit_cnt, exp_hits);
        check("hit1_invuln", bus.invuln, 1);
        check("win_blink_cnt0", bus.blink, 0);
        frames(8, 0);
        check("win_blink_cnt8", bus.blink, 1);
        frames(4, 0);
        check("win_blink_cnt12", bus.blink, 1);
        frames(4, 0);
        check("win_blink_cnt16", bus.blink, 0);
        frames(103, 0);
        check("win_last_invuln", bus.invuln, 1);
        frame(0, 1'b0, 1'b0);
        check("win_end_invuln", bus.invuln, 0);
        check("win_end_blink", bus.blink, 1);
        check("win_end_lives", bus.lives, 4);

        frame(1, 1'b0, 1'b0); exp_hits++;
        check("hit2_lives", bus.lives, 3);
        frames(119, 1);
        check("immune_lives", bus.lives, 3);
        check("immune_invuln", bus.invuln, 1);
        frame(1, 1'b0, 1'b0);
        check("immune_exit_lives", bus.lives, 3);
        check("immune_exit_invuln", bus.invuln, 0);
        frame(1, 1'b0, 1'b0); exp_hits++;
        check("after_win_lives", bus.lives, 2);
        check("after_win_hits", hit_cnt, exp_hits);

        pulse_restart;
        check("restart_invuln_lives", bus.lives, 2);
        check("restart_invuln_invuln", bus.invuln, 1);
        frames(120, 0);
        frame(2, 1'b0, 1'b0); exp_hits++;
        check("enemy_hit_lives", bus.lives, 1);
        check("enemy_hit_gameover", bus.gameover, 0);
        frames(120, 0);
        frame(1, 1'b0, 1'b0); exp_hits++;
        check("fatal_lives", bus.lives, 0);
        check("fatal_gameover", bus.gameover, 1);
        check("fatal_invuln", bus.invuln, 0);
        frames(2, 1);
        check("dead_lives", bus.lives, 0);
        check("dead_hits", hit_cnt, exp_hits);
        pulse_restart;
        check("restart_lives", bus.lives, 5);
        check("restart_gameover", bus.gameover, 0);

        frame(0, 1'b0, 1'b1);
        check("ontick_same_frame", bus.lives, 5);
        frame(0, 1'b0, 1'b0); exp_hits++;
        check("ontick_carried", bus.lives, 4);
        frame(0, 1'b0, 1'b0);
        check("ontick_single", bus.lives, 4);
        check("ontick_hits", hit_cnt, exp_hits);

        frames(5, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_rst_lives", bus.lives, 5);
        check("async_rst_invuln", bus.invuln, 0);
        check("async_rst_blink", bus.blink, 1);
        @(negedge clk);
        reset = 1'b0;
        frame(0, 1'b0, 1'b0);
        check("post_rst_lives", bus.lives, 5);

`ifdef PLAYER_LIVES_EXTRA_EN
        frame(1, 1'b0, 1'b0); frames(120, 0);
        frame(1, 1'b0, 1'b0); frames(120, 0);
        check("pk_pre_lives", bus.lives, 3);
        frame(0, 1'b1, 1'b0);
        check("pk_at3", bus.lives, 4);
        frame(0, 1'b1, 1'b0);
        check("pk_at4", bus.lives, 5);
        frame(0, 1'b1, 1'b0);
        check("pk_at5", bus.lives, 5);
        frame(1, 1'b0, 1'b0); frames(120, 0);
        frame(1, 1'b0, 1'b0); frames(120, 0);
        frame(1, 1'b1, 1'b0);
        check("pk_with_hit", bus.lives, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
